// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared command codes, arbiter FSM states and a constant clog2
// for the stream FIFO write-side scheduling blocks.
package stream_fifo_pkg;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_WRITE   = 3'd1;
    localparam logic [2:0] CMD_COMMIT  = 3'd2;
    localparam logic [2:0] CMD_DISCARD = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_XFER, S_DRAIN, S_CLOSE, S_GAP} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// stream_rr_pick: combinational round-robin picker; returns the first set valid
// bit at or after i_start, wrapping modulo N.
module stream_rr_pick
    import stream_fifo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          i_valid,
    input  logic [clog2(N)-1:0]   i_start,
    output logic [clog2(N)-1:0]   o_idx,
    output logic                  o_any
);

    localparam int IW = clog2(N);

    // Scan offsets from far to near so the nearest valid offset wins.
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (i_valid[(int'(i_start) + k) % N]) o_idx = IW'((int'(i_start) + k) % N);
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/stream_fifo_frame_arbiter.sv
// stream_fifo_frame_arbiter: frame-granular round-robin arbiter driving the write
// side (w_ctrl/w_data) of an asynchronous stream FIFO controller.
module stream_fifo_frame_arbiter
    import stream_fifo_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int DWIDTH    = 8,
    parameter int ADDRWIDTH = 6,
    parameter int FIFODEPTH = 44,
    parameter int MAXFRAME  = 32,
    parameter int MINGAP    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM-1:0]          req_valid,
    input  logic [NUM*DWIDTH-1:0]   req_data,
    input  logic [NUM-1:0]          req_last,
    output logic [NUM-1:0]          req_ready,
    output logic [2:0]              w_ctrl,
    output logic [DWIDTH-1:0]       w_data,
    input  logic                    w_full,
    input  logic                    w_error,
    input  logic [ADDRWIDTH:0]      w_counter,
    output logic [clog2(NUM)-1:0]   grant,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int IW = clog2(NUM);
    localparam int LW = clog2(MAXFRAME + 1);
    localparam int GW = clog2(MINGAP + 1);

    state_t            r_state;
    logic [IW-1:0]     r_grant, r_rr;
    logic [2:0]        r_ctrl;
    logic [DWIDTH-1:0] r_data;
    logic              r_busy, r_abort, r_sent;
    logic [LW-1:0]     r_len;
    logic [GW-1:0]     r_gap;
    logic [7:0]        r_drop;

    logic [IW-1:0]     w_pick;
    logic              w_any, w_space_ok, w_hs, w_last;
    logic [NUM-1:0]    w_ready;
    logic [DWIDTH-1:0] w_word;

    stream_rr_pick #(.N(NUM)) u_pick (
        .i_valid (req_valid),
        .i_start (r_rr),
        .o_idx   (w_pick),
        .o_any   (w_any)
    );

    assign w_space_ok = (int'(w_counter) + MAXFRAME) <= FIFODEPTH;
    assign w_ready    = NUM'((r_state == S_XFER && !w_full) || r_state == S_DRAIN) << r_grant;
    assign w_hs       = req_valid[r_grant] & w_ready[r_grant];
    assign w_last     = req_last[r_grant];
    assign w_word     = req_data[int'(r_grant) * DWIDTH +: DWIDTH];

    // r_abort: frame ends in DISCARD; r_sent: that DISCARD is already on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_rr    <= '0;
            r_ctrl  <= CMD_NOP;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_sent  <= 1'b0;
            r_len   <= '0;
            r_gap   <= '0;
            r_drop  <= '0;
        end else begin
            r_ctrl <= CMD_NOP;
            unique case (r_state)
                S_IDLE: if (w_any && w_space_ok) begin
                    r_grant <= w_pick;
                    r_rr    <= (w_pick == IW'(NUM - 1)) ? '0 : w_pick + IW'(1);
                    r_busy  <= 1'b1;
                    r_len   <= '0;
                    r_abort <= 1'b0;
                    r_sent  <= 1'b0;
                    r_state <= S_XFER;
                end
                S_XFER: if (w_error) begin
                    r_abort <= 1'b1;
                    r_sent  <= !(w_hs && w_last);
                    r_ctrl  <= (w_hs && w_last) ? CMD_NOP : CMD_DISCARD;
                    r_state <= (w_hs && w_last) ? S_CLOSE : S_DRAIN;
                end else if (w_hs) begin
                    r_ctrl <= CMD_WRITE;
                    r_data <= w_word;
                    r_len  <= r_len + LW'(1);
                    if (w_last) r_state <= S_CLOSE;
                    else if (r_len == LW'(MAXFRAME - 1)) begin
                        r_abort <= 1'b1;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_ctrl <= r_sent ? CMD_NOP : CMD_DISCARD;
                    r_sent <= 1'b1;
                    if (w_hs && w_last) r_state <= S_CLOSE;
                end
                S_CLOSE: begin
                    r_ctrl  <= !r_abort ? CMD_COMMIT : (r_sent ? CMD_NOP : CMD_DISCARD);
                    if (r_abort && r_drop != 8'hff) r_drop <= r_drop + 8'd1;
                    r_busy  <= 1'b0;
                    r_gap   <= GW'(MINGAP - 1);
                    r_state <= S_GAP;
                end
                S_GAP: if (r_gap == '0) r_state <= S_IDLE; else r_gap <= r_gap - GW'(1);
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign w_ctrl    = r_ctrl;
    assign w_data    = r_data;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_stream_fifo_frame_arbiter.sv
// tb_stream_fifo_frame_arbiter: directed vector table plus hand-written frame
// sequences for the frame arbiter (NUM=4, FIFODEPTH=44, MAXFRAME=32, MINGAP=6).
module tb_stream_fifo_frame_arbiter;

    localparam int NUM = 4;
    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, COM = 3'd2, DIS = 3'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM-1:0]    req_valid, req_last, req_ready;
    logic [NUM*DW-1:0] req_data;
    logic [2:0]        w_ctrl;
    logic [DW-1:0]     w_data;
    logic              w_full, w_error;
    logic [AW:0]       w_counter;
    logic [1:0]        grant;
    logic              busy;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int errors = 0;
    int t_wr, t_dis, t_com, t_bad, t_lane;

    always #5 clk = ~clk;

    stream_fifo_frame_arbiter #(
        .NUM(NUM), .DWIDTH(DW), .ADDRWIDTH(AW), .FIFODEPTH(44), .MAXFRAME(32), .MINGAP(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .w_ctrl(w_ctrl), .w_data(w_data),
        .w_full(w_full), .w_error(w_error), .w_counter(w_counter), .grant(grant),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] d;
        logic [3:0] rdy;
        logic [2:0] ctrl;
        logic [7:0] data;
        logic       bsy;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lane i carries d + 64*i so a wrong data select shows up in w_data.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [7:0] d,
                         input logic f, input logic e, input logic [6:0] c);
        req_valid = v;
        req_last  = l;
        for (int i = 0; i < NUM; i++) req_data[i*DW +: DW] = d + 8'(i * 64);
        w_full    = f;
        w_error   = e;
        w_counter = c;
        #1;
    endtask

    task automatic do_reset;
        drive(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 7'd0);
        rst_n = 1'b0;
        repeat (2) cyc;
        rst_n = 1'b1;
        #1;
        chk("rst_ctrl", int'(w_ctrl), 0);
        chk("rst_data", int'(w_data), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_cnt), 0);
    endtask

    task automatic tally;
        if (w_ctrl == WR) begin
            t_wr++;
            if (int'(w_data) != ((t_wr + t_lane * 64) & 255)) t_bad++;
        end
        if (w_ctrl == DIS) t_dis++;
        if (w_ctrl == COM) t_com++;
    endtask

    // Word k (1-based) of the frame carries data k; returns handshakes taken.
    task automatic run_frame(input int lane, input int nw, input int err_at,
                             input int full_at, input int full_len,
                             output int nhs, output int full_rdy);
        int fc, ncy;
        logic hs, f, e;
        fc = 0; ncy = 0; nhs = 0; full_rdy = 0;
        t_wr = 0; t_dis = 0; t_com = 0; t_bad = 0; t_lane = lane;
        while (nhs < nw && ncy < 200) begin
            f = (nhs == full_at) && (fc < full_len);
            e = (nhs == err_at);
            drive(4'(1 << lane), (nhs == nw - 1) ? 4'(1 << lane) : 4'd0, 8'(nhs + 1), f, e, 7'd0);
            hs = req_ready[lane];
            if (f) begin
                fc++;
                if (hs) full_rdy++;
            end
            cyc;
            ncy++;
            if (hs) nhs++;
            tally;
        end
        if (ncy >= 200) chk("frame_timeout", nhs, nw);
        drive(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 7'd0);
        repeat (12) begin
            cyc;
            tally;
        end
    endtask

    initial begin
        int wc[NUM];
        int gseq[$];
        int commits, nhs, frdy, ncy, nop_bad;
        logic [3:0] hs4, lst;
        logic pbusy;

        tv[0]  = '{4'h1, 4'h0, 8'hA1, 4'h0, NOP, 8'h00, 1'b1};
        tv[1]  = '{4'h1, 4'h0, 8'hA1, 4'h1, WR,  8'hA1, 1'b1};
        tv[2]  = '{4'h1, 4'h0, 8'hA2, 4'h1, WR,  8'hA2, 1'b1};
        tv[3]  = '{4'h1, 4'h1, 8'hA3, 4'h1, WR,  8'hA3, 1'b1};
        tv[4]  = '{4'h0, 4'h0, 8'h00, 4'h0, COM, 8'hA3, 1'b0};
        for (int i = 5; i <= 10; i++) tv[i] = '{4'h1, 4'h0, 8'hB1, 4'h0, NOP, 8'hA3, 1'b0};
        tv[11] = '{4'h1, 4'h0, 8'hB1, 4'h0, NOP, 8'hA3, 1'b1};
        tv[12] = '{4'h1, 4'h1, 8'hB1, 4'h1, WR,  8'hB1, 1'b1};
        tv[13] = '{4'h0, 4'h0, 8'h00, 4'h0, COM, 8'hB1, 1'b0};

        @(negedge clk);
        do_reset;

        // 3-word frame, minimum gap, then a single-word frame.
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].valid, tv[i].last, tv[i].d, 1'b0, 1'b0, 7'd0);
            chk($sformatf("tv%0d_ready", i), int'(req_ready), int'(tv[i].rdy));
            cyc;
            chk($sformatf("tv%0d_ctrl", i), int'(w_ctrl), int'(tv[i].ctrl));
            chk($sformatf("tv%0d_data", i), int'(w_data), int'(tv[i].data));
            chk($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].bsy));
            chk($sformatf("tv%0d_grant", i), int'(grant), 0);
        end

        // Round robin with all four requesters sending 2-word frames.
        do_reset;
        for (int i = 0; i < NUM; i++) wc[i] = 0;
        commits = 0;
        ncy = 0;
        while (gseq.size() < 5 && ncy < 150) begin
            for (int i = 0; i < NUM; i++) lst[i] = (wc[i] == 1);
            drive(4'hF, lst, 8'(ncy), 1'b0, 1'b0, 7'd0);
            hs4 = req_ready & req_valid;
            pbusy = busy;
            cyc;
            ncy++;
            for (int i = 0; i < NUM; i++) if (hs4[i]) wc[i] = (wc[i] == 1) ? 0 : 1;
            if (w_ctrl == COM) commits++;
            if (!pbusy && busy) begin
                if (gseq.size() > 0) chk("commit_before_grant", commits, 1);
                gseq.push_back(int'(grant));
                commits = 0;
            end
        end
        chk("rr_grant_count", gseq.size(), 5);
        for (int k = 0; k < gseq.size(); k++) chk($sformatf("rr_grant%0d", k), gseq[k], k % 4);

        // Space threshold: 44-13=31 < 32 blocks, 44-12=32 grants.
        do_reset;
        for (int i = 0; i < 3; i++) begin
            drive(4'h8, 4'h0, 8'h11, 1'b0, 1'b0, 7'd13);
            cyc;
            chk("space13_busy", int'(busy), 0);
        end
        drive(4'h8, 4'h0, 8'h11, 1'b0, 1'b0, 7'd12);
        cyc;
        chk("space12_busy", int'(busy), 1);
        chk("space12_grant", int'(grant), 3);

        // Oversize: 34 words, last on the 34th.
        do_reset;
        run_frame(0, 34, -1, -1, 0, nhs, frdy);
        chk("ovs_handshakes", nhs, 34);
        chk("ovs_writes", t_wr, 32);
        chk("ovs_discards", t_dis, 1);
        chk("ovs_commits", t_com, 0);
        chk("ovs_data_bad", t_bad, 0);
        chk("ovs_drop_cnt", int'(drop_cnt), 1);

        // w_error on word 2 of a 5-word frame.
        do_reset;
        run_frame(0, 5, 1, -1, 0, nhs, frdy);
        chk("err_handshakes", nhs, 5);
        chk("err_writes", t_wr, 1);
        chk("err_discards", t_dis, 1);
        chk("err_commits", t_com, 0);
        chk("err_data_bad", t_bad, 0);
        chk("err_drop_cnt", int'(drop_cnt), 1);

        // w_full held 4 cycles after word 2 of a 6-word frame on lane 1.
        do_reset;
        run_frame(1, 6, -1, 2, 4, nhs, frdy);
        chk("full_ready_while_full", frdy, 0);
        chk("full_writes", t_wr, 6);
        chk("full_commits", t_com, 1);
        chk("full_discards", t_dis, 0);
        chk("full_data_bad", t_bad, 0);
        chk("full_drop_cnt", int'(drop_cnt), 0);

        // Reset mid-frame on lane 2.
        do_reset;
        drive(4'h4, 4'h0, 8'h05, 1'b0, 1'b0, 7'd0);
        repeat (3) cyc;
        chk("mid_busy_before", int'(busy), 1);
        chk("mid_grant_before", int'(grant), 2);
        chk("mid_ctrl_before", int'(w_ctrl), int'(WR));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", int'(w_ctrl), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        drive(4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 7'd0);
        cyc;
        rst_n = 1'b1;
        nop_bad = 0;
        repeat (8) begin
            cyc;
            if (w_ctrl != NOP) nop_bad++;
        end
        chk("mid_no_end_cmd", nop_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
